// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: PC register, instruction memory and decode-side channels.
// master = fetch unit, slave = surrounding pipeline / memory.
interface fetch_unit_if;
   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic        pc_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;

   modport master (
      input  pc_q, redirect_valid, redirect_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  if_ready,
      output pc_next, pc_en, imem_req_valid, imem_req_addr,
      output if_valid, if_instr, if_pc
   );

   modport slave (
      output pc_q, redirect_valid, redirect_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output if_ready,
      input  pc_next, pc_en, imem_req_valid, imem_req_addr,
      input  if_valid, if_instr, if_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch with tag queue and decode buffer.
// Define FETCH_BYPASS_EN for same-cycle response-to-decode bypass.
module fetch_unit #(
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] out_q, out_d;
   logic [PW-1:0] bwr_q, bwr_d, brd_q, brd_d;
   logic [PW-1:0] twr_q, twr_d, trd_q, trd_d;
   logic [31:0]   buf_pc_q  [DEPTH];
   logic [31:0]   buf_ins_q [DEPTH];
   logic [31:0]   tag_q     [DEPTH];

   logic          accept, resp_run, resp_any;
   logic          push, pop, bypass, has_data, credit;
   logic [CW:0]   inflight;

   always_comb begin
      inflight = {1'b0, cnt_q} + {1'b0, out_q};
      credit   = inflight < DEPTH_W;
      has_data = cnt_q != '0;
      resp_run = bus.imem_resp_valid && (state_q == RUN);
      resp_any = bus.imem_resp_valid && (state_q != IDLE);
`ifdef FETCH_BYPASS_EN
      bypass = resp_run && !has_data;
`else
      bypass = 1'b0;
`endif
      pop  = has_data && bus.if_ready;
      // A bypassed response consumed in the same cycle never lands in the buffer
      push = resp_run && !(bypass && bus.if_ready);

      bus.imem_req_valid = !reset && (state_q == RUN) && credit &&
                           !bus.redirect_valid;
      accept             = bus.imem_req_valid && bus.imem_req_ready;
      bus.imem_req_addr  = reset ? '0 : bus.pc_q;
      bus.pc_en          = !reset && (bus.redirect_valid || accept);
      bus.pc_next        = '0;
      if (bus.pc_en)
         bus.pc_next = bus.redirect_valid ? bus.redirect_pc
                                          : bus.pc_q + 32'd4;

      bus.if_valid = !reset && (has_data || bypass);
      bus.if_instr = '0;
      bus.if_pc    = '0;
      if (has_data) begin
         bus.if_instr = buf_ins_q[brd_q];
         bus.if_pc    = buf_pc_q[brd_q];
      end else if (bypass) begin
         bus.if_instr = bus.imem_resp_data;
         bus.if_pc    = tag_q[trd_q];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      bwr_d   = bwr_q;
      brd_d   = brd_q;
      twr_d   = twr_q;
      trd_d   = trd_q;

      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      unique case ({accept, resp_any})
         2'b10:   out_d = out_q + CW'(1);
         2'b01:   out_d = out_q - CW'(1);
         default: out_d = out_q;
      endcase
      if (push)     bwr_d = bwr_q + PW'(1);
      if (pop)      brd_d = brd_q + PW'(1);
      if (accept)   twr_d = twr_q + PW'(1);
      if (resp_run) trd_d = trd_q + PW'(1);

      unique case (state_q)
         IDLE:    state_d = RUN;
         RUN:     state_d = RUN;
         DRAIN:   if (out_d == '0) state_d = RUN;
         default: state_d = IDLE;
      endcase

      // Redirect flushes everything; in-flight responses are dropped in DRAIN
      if (bus.redirect_valid && state_q != IDLE) begin
         cnt_d   = '0;
         bwr_d   = '0;
         brd_d   = '0;
         twr_d   = '0;
         trd_d   = '0;
         state_d = (out_d != '0) ? DRAIN : RUN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         bwr_q   <= '0;
         brd_q   <= '0;
         twr_q   <= '0;
         trd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         bwr_q   <= bwr_d;
         brd_q   <= brd_d;
         twr_q   <= twr_d;
         trd_q   <= trd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc_q[bwr_q]  <= tag_q[trd_q];
         buf_ins_q[bwr_q] <= bus.imem_resp_data;
      end
      if (accept)
         tag_q[twr_q] <= bus.pc_q;
   end
endmodule
